// File: rtl/adpcm_decoder.sv
// IMA ADPCM decoder: accepts one 4-bit code and reconstructs one signed 16-bit sample,
// sequenced as IDLE -> LOOKUP -> COMPUTE -> OUTPUT with one cycle per non-idle state.
module adpcm_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        block_enable,
    input  logic        inValid,
    input  logic [3:0]  encPcm,
    output logic        ready,
    output logic        outValid,
    output logic [15:0] decPcm
);
    localparam int DATA_W = 16;
    localparam int STEP_W = 15;
    localparam int DIFF_W = DATA_W + 1;
    localparam int SUM_W  = DATA_W + 2;
    localparam logic [6:0] INDEX_MAX = 7'd88;
    localparam logic signed [SUM_W-1:0] SAMPLE_MAX = 18'sd32767;
    localparam logic signed [SUM_W-1:0] SAMPLE_MIN = -18'sd32768;

    localparam logic [STEP_W-1:0] STEP_TABLE [0:88] = '{
        15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
        15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
        15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
        15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
        15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
        15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
        15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
        15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
        15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
        15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
        15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
        15'd32767
    };

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOOKUP  = 2'd1,
        S_COMPUTE = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    state_t                     state;
    state_t                     next_state;
    logic                       accept;
    logic signed [DATA_W-1:0]   predictor;
    logic [6:0]                 index;
    logic [3:0]                 code;
    logic [STEP_W-1:0]          step;
    logic [DIFF_W-1:0]          diff;
    logic signed [SUM_W-1:0]    pred_ext;
    logic signed [SUM_W-1:0]    diff_ext;
    logic signed [SUM_W-1:0]    sum;
    logic signed [DATA_W-1:0]   pred_next;
    logic [6:0]                 index_next;

    // Shift-and-add reconstruction of |diff| from the step size and code magnitude.
    function automatic logic [DIFF_W-1:0] step_diff(input logic [STEP_W-1:0] s,
                                                     input logic [2:0] mag);
        logic [DIFF_W-1:0] se;
        logic [DIFF_W-1:0] acc;
        se  = DIFF_W'(s);
        acc = se >> 3;
        if (mag[2]) acc = acc + se;
        if (mag[1]) acc = acc + (se >> 1);
        if (mag[0]) acc = acc + (se >> 2);
        return acc;
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
        if (v > SAMPLE_MAX)
            return 16'sh7fff;
        else if (v < SAMPLE_MIN)
            return 16'sh8000;
        else
            return DATA_W'(v);
    endfunction

    function automatic logic [6:0] next_index(input logic [6:0] idx, input logic [2:0] mag);
        logic signed [7:0] adj;
        logic signed [7:0] total;
        case (mag)
            3'd4:    adj = 8'sd2;
            3'd5:    adj = 8'sd4;
            3'd6:    adj = 8'sd6;
            3'd7:    adj = 8'sd8;
            default: adj = -8'sd1;
        endcase
        total = $signed({1'b0, idx}) + adj;
        if (total < 8'sd0)
            return 7'd0;
        else if (total > $signed({1'b0, INDEX_MAX}))
            return INDEX_MAX;
        else
            return 7'(total);
    endfunction

    assign accept = (state == S_IDLE) && inValid && block_enable;

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (inValid && block_enable) next_state = S_LOOKUP;
            S_LOOKUP:  next_state = S_COMPUTE;
            S_COMPUTE: next_state = S_OUTPUT;
            S_OUTPUT:  next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        ready    = (state == S_IDLE);
        outValid = (state == S_OUTPUT);
    end

    // The step used here comes from the index before this code's update.
    always_comb begin
        diff       = step_diff(step, code[2:0]);
        pred_ext   = {{(SUM_W-DATA_W){predictor[DATA_W-1]}}, predictor};
        diff_ext   = {1'b0, diff};
        sum        = code[3] ? (pred_ext - diff_ext) : (pred_ext + diff_ext);
        pred_next  = saturate(sum);
        index_next = next_index(index, code[2:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            predictor <= '0;
            index     <= '0;
            code      <= '0;
            step      <= '0;
            decPcm    <= '0;
        end else begin
            if (accept)
                code <= encPcm;
            if (state == S_LOOKUP)
                step <= STEP_TABLE[index];
            if (state == S_COMPUTE) begin
                predictor <= pred_next;
                decPcm    <= pred_next;
                index     <= index_next;
            end
        end
    end

endmodule

// File: tb/tb_adpcm_decoder.sv
// Self-checking bench for adpcm_decoder: directed scenarios plus randomized codes
// compared against an integer-arithmetic IMA ADPCM reference model.
module tb_adpcm_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        block_enable;
    logic        inValid;
    logic [3:0]  encPcm;
    logic        ready;
    logic        outValid;
    logic [15:0] decPcm;

    int n_tests = 0;
    int n_fail  = 0;
    int m_pred;
    int m_idx;

    int step_tab [0:88] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
        19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
        130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
        337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
        876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
        2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
        5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
        15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };

    adpcm_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .block_enable (block_enable),
        .inValid      (inValid),
        .encPcm       (encPcm),
        .ready        (ready),
        .outValid     (outValid),
        .decPcm       (decPcm)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pred = 0;
        m_idx  = 0;
    endtask

    task automatic model_decode(input logic [3:0] c);
        int st;
        int diff;
        int mag;
        st   = step_tab[m_idx];
        diff = st / 8;
        if (c[2]) diff += st;
        if (c[1]) diff += st / 2;
        if (c[0]) diff += st / 4;
        m_pred = c[3] ? (m_pred - diff) : (m_pred + diff);
        if (m_pred > 32767)  m_pred = 32767;
        if (m_pred < -32768) m_pred = -32768;
        mag = int'(c[2:0]);
        m_idx += (mag < 4) ? -1 : 2 * (mag - 3);
        if (m_idx < 0)  m_idx = 0;
        if (m_idx > 88) m_idx = 88;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        inValid = 1'b0;
        block_enable = 1'b0;
        encPcm = 4'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (!ready && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        ok = ready;
    endtask

    // Presents one code, drops block_enable while it is in flight, and reports the
    // number of edges from accept (inclusive) to outValid, or -1 if it never came.
    task automatic send_code(input logic [3:0] c, output int lat, output logic [15:0] dec);
        bit ok;
        bit seen;
        wait_ready(ok);
        encPcm = c;
        inValid = 1'b1;
        block_enable = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        block_enable = 1'b0;
        encPcm = 4'($urandom);
        lat = -1;
        dec = decPcm;
        seen = 1'b0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(posedge clk); #1;
            if (outValid) begin
                seen = 1'b1;
                lat = i + 1;
                dec = decPcm;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        logic [15:0] dec;
        do_reset();
        send_code(4'h7, lat, dec);
        do_reset();
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_tests++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid: got %b want 0", outValid); end
        n_tests++; if (decPcm !== 16'h0000) begin n_fail++; $display("FAIL reset_decpcm: got %h want 0000", decPcm); end
        n_tests++; if (dut.index !== 7'd0) begin n_fail++; $display("FAIL reset_index: got %0d want 0", dut.index); end
        n_tests++; if (dut.code !== 4'h0) begin n_fail++; $display("FAIL reset_code: got %h want 0", dut.code); end
        n_tests++; if (dut.step !== 15'd0) begin n_fail++; $display("FAIL reset_step: got %0d want 0", dut.step); end
    endtask

    task automatic test_basic();
        int lat;
        logic [15:0] dec;
        do_reset();
        send_code(4'h4, lat, dec);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", lat); end
        n_tests++; if (dec !== 16'd7) begin n_fail++; $display("FAIL basic_dec1: got %0d want 7", $signed(dec)); end
        n_tests++; if (dut.index !== 7'd2) begin n_fail++; $display("FAIL basic_idx1: got %0d want 2", dut.index); end
        @(posedge clk); #1;
        n_tests++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b want 0", outValid); end
        n_tests++; if (decPcm !== 16'd7) begin n_fail++; $display("FAIL basic_hold: got %0d want 7", $signed(decPcm)); end
        send_code(4'h4, lat, dec);
        n_tests++; if (dec !== 16'd17) begin n_fail++; $display("FAIL basic_dec2: got %0d want 17", $signed(dec)); end
        n_tests++; if (dut.index !== 7'd4) begin n_fail++; $display("FAIL basic_idx2: got %0d want 4", dut.index); end
    endtask

    task automatic test_sign();
        int lat;
        logic [15:0] dec;
        do_reset();
        send_code(4'h7, lat, dec);
        n_tests++; if (dec !== 16'd11) begin n_fail++; $display("FAIL sign_pos_dec: got %0d want 11", $signed(dec)); end
        n_tests++; if (dut.index !== 7'd8) begin n_fail++; $display("FAIL sign_pos_idx: got %0d want 8", dut.index); end
        do_reset();
        send_code(4'hF, lat, dec);
        n_tests++; if (dec !== 16'hFFF5) begin n_fail++; $display("FAIL sign_neg_dec: got %h want fff5", dec); end
        n_tests++; if (dut.index !== 7'd8) begin n_fail++; $display("FAIL sign_neg_idx: got %0d want 8", dut.index); end
    endtask

    task automatic test_zero();
        int lat;
        logic [15:0] dec;
        do_reset();
        send_code(4'h0, lat, dec);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL zero_latency: got %0d want 3", lat); end
        n_tests++; if (dec !== 16'd0) begin n_fail++; $display("FAIL zero_dec: got %0d want 0", $signed(dec)); end
        n_tests++; if (dut.index !== 7'd0) begin n_fail++; $display("FAIL zero_idx_clamp: got %0d want 0", dut.index); end
        send_code(4'h8, lat, dec);
        n_tests++; if (dec !== 16'd0) begin n_fail++; $display("FAIL zero_neg_dec: got %0d want 0", $signed(dec)); end
        n_tests++; if (dut.index !== 7'd0) begin n_fail++; $display("FAIL zero_neg_idx: got %0d want 0", dut.index); end
    endtask

    task automatic test_saturation();
        int lat;
        int wraps;
        int prev;
        logic [15:0] dec;
        do_reset();
        wraps = 0;
        prev = 0;
        for (int i = 0; i < 40; i++) begin
            send_code(4'h7, lat, dec);
            model_decode(4'h7);
            n_tests++;
            if (dec !== 16'(m_pred)) begin
                n_fail++; $display("FAIL sat_pos_step%0d: got %0d want %0d", i, $signed(dec), m_pred);
            end
            if (int'($signed(dec)) < prev) wraps++;
            prev = int'($signed(dec));
        end
        n_tests++; if (wraps !== 0) begin n_fail++; $display("FAIL sat_pos_nowrap: got %0d wraps want 0", wraps); end
        n_tests++; if (dec !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos_final: got %h want 7fff", dec); end
        n_tests++; if (dut.index !== 7'd88) begin n_fail++; $display("FAIL sat_idx_final: got %0d want 88", dut.index); end
        do_reset();
        wraps = 0;
        prev = 0;
        for (int i = 0; i < 40; i++) begin
            send_code(4'hF, lat, dec);
            model_decode(4'hF);
            n_tests++;
            if (dec !== 16'(m_pred)) begin
                n_fail++; $display("FAIL sat_neg_step%0d: got %0d want %0d", i, $signed(dec), m_pred);
            end
            if (int'($signed(dec)) > prev) wraps++;
            prev = int'($signed(dec));
        end
        n_tests++; if (wraps !== 0) begin n_fail++; $display("FAIL sat_neg_nowrap: got %0d wraps want 0", wraps); end
        n_tests++; if (dec !== 16'h8000) begin n_fail++; $display("FAIL sat_neg_final: got %h want 8000", dec); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] q[$];
        logic [3:0] c;
        logic [15:0] hold;
        int vld_err;
        int rdy_err;
        int pulses;
        int stray;
        bit exp_v;
        bit exp_r;
        do_reset();
        vld_err = 0; rdy_err = 0; pulses = 0;
        inValid = 1'b1;
        block_enable = 1'b1;
        for (int e = 0; e < 40; e++) begin
            encPcm = 4'($urandom);
            if (e % 4 == 0) q.push_back(encPcm);
            @(posedge clk); #1;
            exp_v = ((e + 1) % 4 == 3);
            exp_r = ((e + 1) % 4 == 0);
            if (outValid !== exp_v) vld_err++;
            if (ready !== exp_r) rdy_err++;
            if (outValid === 1'b1) pulses++;
            if (outValid === 1'b1 && exp_v && q.size() > 0) begin
                c = q.pop_front();
                model_decode(c);
                n_tests++;
                if (decPcm !== 16'(m_pred)) begin
                    n_fail++; $display("FAIL b2b_dec_e%0d: got %0d want %0d", e, $signed(decPcm), m_pred);
                end
            end
        end
        n_tests++; if (vld_err !== 0) begin n_fail++; $display("FAIL b2b_outvalid_timing: got %0d bad cycles want 0", vld_err); end
        n_tests++; if (rdy_err !== 0) begin n_fail++; $display("FAIL b2b_ready_timing: got %0d bad cycles want 0", rdy_err); end
        n_tests++; if (pulses !== 10) begin n_fail++; $display("FAIL b2b_accept_count: got %0d want 10", pulses); end
        // block_enable low in IDLE must block acceptance entirely
        block_enable = 1'b0;
        hold = decPcm;
        stray = 0;
        for (int e = 0; e < 12; e++) begin
            encPcm = 4'($urandom);
            @(posedge clk); #1;
            if (outValid !== 1'b0 || ready !== 1'b1 || decPcm !== hold) stray++;
        end
        inValid = 1'b0;
        n_tests++; if (stray !== 0) begin n_fail++; $display("FAIL gate_block_enable: got %0d bad cycles want 0", stray); end
    endtask

    task automatic test_abort();
        int lat;
        int stray;
        bit ok;
        logic [15:0] dec;
        do_reset();
        send_code(4'h7, lat, dec);
        wait_ready(ok);
        encPcm = 4'h4;
        inValid = 1'b1;
        block_enable = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        block_enable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        n_tests++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL abort_outvalid: got %b want 0", outValid); end
        n_tests++; if (decPcm !== 16'd0) begin n_fail++; $display("FAIL abort_decpcm: got %0d want 0", $signed(decPcm)); end
        n_tests++; if (dut.index !== 7'd0) begin n_fail++; $display("FAIL abort_index: got %0d want 0", dut.index); end
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (outValid !== 1'b0) stray++;
        end
        n_tests++; if (stray !== 0) begin n_fail++; $display("FAIL abort_no_pulse: got %0d pulses want 0", stray); end
        send_code(4'h4, lat, dec);
        n_tests++; if (dec !== 16'd7) begin n_fail++; $display("FAIL abort_next_dec: got %0d want 7", $signed(dec)); end
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL abort_next_latency: got %0d want 3", lat); end
    endtask

    task automatic test_random();
        int lat;
        logic [3:0] c;
        logic [15:0] dec;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            c = 4'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send_code(c, lat, dec);
            model_decode(c);
            n_tests++;
            if (lat !== 3 || dec !== 16'(m_pred) || dut.index !== 7'(m_idx)) begin
                n_fail++;
                $display("FAIL random_%0d code=%h: got lat=%0d dec=%0d idx=%0d want lat=3 dec=%0d idx=%0d",
                         i, c, lat, $signed(dec), dut.index, m_pred, m_idx);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        inValid = 1'b0;
        block_enable = 1'b0;
        encPcm = 4'h0;
        test_reset();
        test_basic();
        test_sign();
        test_zero();
        test_saturation();
        test_back_to_back();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
